player_motion_controller: RTL and testbench
===========================================

// Module: player_motion_controller
// PURPOSE
//  Per game tick, requests a background collision check around the player tile and waits for it to finish.
//  Then applies horizontal moves, jump and gravity, writing the result back to player (x,y) in tiles.
//  Drives x_location/y_location/enable of the background collision detector; consumes its left/right/up/down/done.
//  Downstream: sprite renderer and scroll logic read x_location/y_location.
// PARAMETERS
//  MAP_LENGTH   2000  tilemap width in tiles; x range 0..MAP_LENGTH-1
//  START_X      2     x tile after reset
//  START_Y      1     y tile after reset (y=0 bottom row, y grows upward)
//  JUMP_HEIGHT  3     tiles risen per jump (>=1)
//  TIMEOUT      63    max cycles spent in each collision wait state before abort
// PORTS
//  clock        in   1   system clock
//  resetn       in   1   asynchronous reset, active-low
//  game_tick    in   1   one-cycle pulse: start one motion update
//  btn_left     in   1   move-left request, sampled on accepted tick
//  btn_right    in   1   move-right request, sampled on accepted tick
//  btn_jump     in   1   jump request, sampled on accepted tick
//  coll_left    in   1   tile at x-1 solid (from detector)
//  coll_right   in   1   tile at x+1 solid
//  coll_up      in   1   tile at y+1 solid
//  coll_down    in   1   tile at y-1 solid (grounded)
//  coll_done    in   1   detector idle; high when idle, low while checking
//  coll_enable  out  1   one-cycle start pulse to detector
//  x_location   out  11  player x tile
//  y_location   out  4   player y tile
//  busy         out  1   high in any state except IDLE
//  tick_overrun out  1   sticky; set when game_tick arrives while busy
//  coll_timeout out  1   sticky; set when a collision wait aborts
// BEHAVIOUR
//  Reset (async): x=START_X, y=START_Y, jump_cnt=0, state IDLE, all 1-bit outputs 0.
//  FSM: IDLE -> START -> WAIT_LOW -> WAIT_HIGH -> MOVE -> IDLE.
//   IDLE: on game_tick, latch btn_* and go to START. Sticky flags clear only on reset.
//   START: coll_enable=1 for exactly this cycle; x/y held stable from START until MOVE completes.
//   WAIT_LOW: wait for coll_done=0; WAIT_HIGH: wait for coll_done=1.
//   Each wait state has a cycle counter, cleared on entry. Reaching TIMEOUT sets coll_timeout and returns to IDLE with no move.
//   MOVE (1 cycle): apply all updates from the coll_* values sampled this cycle; then IDLE.
//  Horizontal (latched buttons):
//   left only: x-=1 if !coll_left && x>0.
//   right only: x+=1 if !coll_right && x<MAP_LENGTH-1.
//   Both or neither: no horizontal move.
//  Vertical, evaluated in priority order:
//   1. jump_cnt>0: if coll_up || y==15, set jump_cnt=0 and hold y; else y+=1, jump_cnt-=1.
//   2. jump latched && coll_down: start a jump; if !coll_up && y<15, y+=1 and jump_cnt=JUMP_HEIGHT-1; else jump_cnt=0.
//   3. !coll_down && y>0: y-=1 (gravity).
//   4. Otherwise hold y.
//   Horizontal and vertical updates land in the same MOVE cycle.
//  game_tick while busy: the tick is dropped and tick_overrun set; the same cycle the FSM returns to IDLE counts as busy.
//  Latency: tick to updated x/y = 4 + detector cycles; no combinational path from inputs to outputs.
//  Reset mid-update: the FSM returns to IDLE immediately, a partial update is discarded, and coll_enable drops.
// TESTING
//  Reset with START_X=2, START_Y=1: x=2, y=1, busy=0, flags 0, coll_enable=0.
//  Tick with btn_right and detector model returning all coll_* 0: 1-cycle coll_enable; after done rises, x=3 and y=0 (fell).
//  y=0, coll_down=1, btn_jump, no up collision: y goes 1,2,3 over 3 ticks, then falls back to 0 over 3 more ticks.
//  Jump from y=5 with coll_up=1 on the second tick: y=6, then jump_cnt cleared and y held; next tick with coll_down=0 gives y=5.
//  x=0 with btn_left; x=MAP_LENGTH-1 with btn_right; both buttons pressed: x unchanged in each case.
//  Detector model that never drops coll_done: coll_timeout=1 after TIMEOUT cycles and x/y unchanged. A tick mid-update sets tick_overrun.

Source files
------------

// File: rtl/player_motion_controller.sv
// Player motion controller: per game tick, asks the background collision
// detector about the tiles around the player, waits for it, then applies
// horizontal moves, jump and gravity to the player tile position.
// Ports:
//   clock, resetn        system clock, async active-low reset
//   game_tick            one-cycle pulse starting a motion update
//   btn_left/right/jump  button requests, latched on an accepted tick
//   coll_left/right/up/down, coll_done   detector results / idle flag
//   coll_enable          one-cycle start pulse to the detector
//   x_location, y_location   player tile position (y=0 is the bottom row)
//   busy                 high whenever an update is in flight
//   tick_overrun         sticky: a tick arrived while busy
//   coll_timeout         sticky: a detector wait was aborted
module player_motion_controller #(
   parameter int MAP_LENGTH  = 2000,
   parameter int START_X     = 2,
   parameter int START_Y     = 1,
   parameter int JUMP_HEIGHT = 3,
   parameter int TIMEOUT     = 63
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        game_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic        coll_left,
   input  logic        coll_right,
   input  logic        coll_up,
   input  logic        coll_down,
   input  logic        coll_done,
   output logic        coll_enable,
   output logic [10:0] x_location,
   output logic [3:0]  y_location,
   output logic        busy,
   output logic        tick_overrun,
   output logic        coll_timeout
);

   typedef enum logic [2:0] {
      IDLE, START, WAIT_LOW, WAIT_HIGH, MOVE
   } state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [10:0]   X_MAX    = 11'(MAP_LENGTH - 1);

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [10:0]   x_n;
   logic [3:0]    y_n;
   logic [3:0]    jump_cnt, jump_n;
   // latched buttons: {jump, right, left}
   logic [2:0]    btn, btn_n;
   logic          overrun_n, timeout_n;

   // Both outputs decode the state register only, so no input reaches
   // an output combinationally.
   assign coll_enable = (state == START);
   assign busy        = (state != IDLE);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state        <= IDLE;
         cnt          <= '0;
         x_location   <= 11'(START_X);
         y_location   <= 4'(START_Y);
         jump_cnt     <= '0;
         btn          <= '0;
         tick_overrun <= 1'b0;
         coll_timeout <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         x_location   <= x_n;
         y_location   <= y_n;
         jump_cnt     <= jump_n;
         btn          <= btn_n;
         tick_overrun <= overrun_n;
         coll_timeout <= timeout_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      x_n       = x_location;
      y_n       = y_location;
      jump_n    = jump_cnt;
      btn_n     = btn;
      overrun_n = tick_overrun | (game_tick & (state != IDLE));
      timeout_n = coll_timeout;

      unique case (state)
         IDLE: begin
            if (game_tick) begin
               btn_n   = {btn_jump, btn_right, btn_left};
               state_n = START;
            end
         end
         START: begin
            cnt_n   = '0;
            state_n = WAIT_LOW;
         end
         WAIT_LOW: begin
            if (!coll_done) begin
               cnt_n   = '0;
               state_n = WAIT_HIGH;
            end else if (cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            if (coll_done) begin
               state_n = MOVE;
            end else if (cnt == CNT_LAST) begin
               timeout_n = 1'b1;
               state_n   = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         MOVE: begin
            state_n = IDLE;
            if (btn[0] && !btn[1]) begin
               if (!coll_left && x_location != 11'd0)
                  x_n = x_location - 11'd1;
            end else if (btn[1] && !btn[0]) begin
               if (!coll_right && x_location < X_MAX)
                  x_n = x_location + 11'd1;
            end
            // vertical rules in priority order: rising, jump start, gravity
            if (jump_cnt != 4'd0) begin
               if (coll_up || y_location == 4'd15) begin
                  jump_n = 4'd0;
               end else begin
                  y_n    = y_location + 4'd1;
                  jump_n = jump_cnt - 4'd1;
               end
            end else if (btn[2] && coll_down) begin
               if (!coll_up && y_location != 4'd15) begin
                  y_n    = y_location + 4'd1;
                  jump_n = 4'(JUMP_HEIGHT - 1);
               end else begin
                  jump_n = 4'd0;
               end
            end else if (!coll_down && y_location != 4'd0) begin
               y_n = y_location - 4'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_player_motion_controller.sv
// Testbench for player_motion_controller: directed and random ticks,
// detector behaviour modelled inline, position checked against a model.
module tb_player_motion_controller;

   localparam int MAP = 2000;
   localparam int JH  = 3;

   logic        clock, resetn, game_tick;
   logic        btn_left, btn_right, btn_jump;
   logic        coll_left, coll_right, coll_up, coll_down, coll_done;
   logic        coll_enable, busy, tick_overrun, coll_timeout;
   logic [10:0] x_location;
   logic [3:0]  y_location;

   int n_cmp = 0;
   int n_bad = 0;
   int mx, my, mj;

   player_motion_controller dut (
      .clock(clock), .resetn(resetn), .game_tick(game_tick),
      .btn_left(btn_left), .btn_right(btn_right), .btn_jump(btn_jump),
      .coll_left(coll_left), .coll_right(coll_right),
      .coll_up(coll_up), .coll_down(coll_down), .coll_done(coll_done),
      .coll_enable(coll_enable), .x_location(x_location),
      .y_location(y_location), .busy(busy),
      .tick_overrun(tick_overrun), .coll_timeout(coll_timeout)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // reference: position after one completed update
   task automatic model(input bit l, r, j, cl, cr, cu, cd);
      if (l && !r && !cl && mx > 0) mx = mx - 1;
      if (r && !l && !cr && mx < MAP - 1) mx = mx + 1;
      if (mj > 0) begin
         if (cu || my == 15) mj = 0;
         else begin my = my + 1; mj = mj - 1; end
      end else if (j && cd) begin
         if (!cu && my < 15) begin my = my + 1; mj = JH - 1; end
         else mj = 0;
      end else if (!cd && my > 0) begin
         my = my - 1;
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      game_tick = 0; btn_left = 0; btn_right = 0; btn_jump = 0;
      coll_left = 0; coll_right = 0; coll_up = 0; coll_down = 0;
      coll_done = 1'b1;
      repeat (2) step();
      resetn = 1'b1;
      step();
      mx = 2; my = 1; mj = 0;
   endtask

   task automatic do_tick(input bit l, r, j, cl, cr, cu, cd, ovr);
      int k;
      btn_left = l; btn_right = r; btn_jump = j;
      coll_left = cl; coll_right = cr; coll_up = cu; coll_down = cd;
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      // buttons must have been latched; flip them afterwards
      btn_left = ~l; btn_right = ~r; btn_jump = ~j;
      chk("enable_pulse", coll_enable, 1);
      step();
      chk("enable_drop", coll_enable, 0);
      if (ovr) begin
         game_tick = 1'b1;
         step();
         game_tick = 1'b0;
      end
      repeat ($urandom_range(0, 2)) step();
      coll_done = 1'b0;
      repeat ($urandom_range(1, 3)) step();
      coll_done = 1'b1;
      k = 0;
      while (busy && k < 12) begin step(); k++; end
      chk("busy_drop", busy, 0);
      model(l, r, j, cl, cr, cu, cd);
      chk("x", x_location, mx);
      chk("y", y_location, my);
   endtask

   initial begin
      int guard;
      do_reset();
      chk("rst_x", x_location, 2);
      chk("rst_y", y_location, 1);
      chk("rst_busy", busy, 0);
      chk("rst_enable", coll_enable, 0);
      chk("rst_overrun", tick_overrun, 0);
      chk("rst_timeout", coll_timeout, 0);

      // detector that never drops done: wait aborts, mid-update tick
      btn_right = 1; btn_jump = 1;
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      repeat (20) step();
      chk("to_busy", busy, 1);
      chk("to_early", coll_timeout, 0);
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      chk("overrun_set", tick_overrun, 1);
      guard = 0;
      while (busy && guard < 80) begin step(); guard++; end
      chk("to_done", busy, 0);
      chk("to_flag", coll_timeout, 1);
      chk("to_x", x_location, 2);
      chk("to_y", y_location, 1);
      repeat (3) step();
      chk("to_sticky", coll_timeout, 1);
      do_reset();
      chk("clr_timeout", coll_timeout, 0);
      chk("clr_overrun", tick_overrun, 0);

      // right with no collisions: moves and falls
      do_tick(0, 1, 0, 0, 0, 0, 0, 0);
      chk("first_x", x_location, 3);
      chk("first_y", y_location, 0);

      // jump from the floor: up 3, down 3
      do_tick(0, 0, 1, 0, 0, 0, 1, 0);
      do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      chk("jump_peak", y_location, 3);
      repeat (3) do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      chk("jump_land", y_location, 0);

      // climb to y=5 standing, then jump into a ceiling
      do_tick(0, 0, 1, 0, 0, 0, 1, 0);
      do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      do_tick(0, 0, 1, 0, 0, 0, 1, 0);
      do_tick(0, 0, 0, 0, 0, 1, 0, 0);
      do_tick(0, 0, 1, 0, 0, 0, 1, 0);
      do_tick(0, 0, 0, 0, 0, 1, 0, 0);
      chk("pre_ceiling_y", y_location, 5);
      do_tick(0, 0, 1, 0, 0, 0, 1, 0);
      chk("ceiling_up", y_location, 6);
      do_tick(0, 0, 0, 0, 0, 1, 0, 0);
      chk("ceiling_hold", y_location, 6);
      do_tick(0, 0, 0, 0, 0, 0, 0, 0);
      chk("ceiling_fall", y_location, 5);

      // blocked moves and both buttons
      do_tick(1, 0, 0, 1, 0, 0, 1, 0);
      do_tick(0, 1, 0, 0, 1, 0, 1, 0);
      do_tick(1, 1, 0, 0, 0, 0, 1, 0);
      chk("blocked_x", x_location, 3);

      // left edge
      guard = 0;
      while (mx > 0 && guard < 10) begin
         do_tick(1, 0, 0, 0, 0, 0, 1, 0);
         guard++;
      end
      do_tick(1, 0, 0, 0, 0, 0, 1, 0);
      chk("left_edge", x_location, 0);

      // right edge
      guard = 0;
      while (mx < MAP - 1 && guard < 2100) begin
         do_tick(0, 1, 0, 0, 0, 0, 1, 0);
         guard++;
      end
      do_tick(0, 1, 0, 0, 0, 0, 1, 0);
      chk("right_edge", x_location, MAP - 1);

      // random ticks
      for (int i = 0; i < 300; i++) begin
         do_tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'b0);
      end

      // dropped tick during a normal update
      chk("ovr_clear", tick_overrun, 0);
      do_tick(0, 1, 0, 0, 0, 0, 1, 1);
      chk("ovr_sticky", tick_overrun, 1);

      // reset while coll_enable is high
      btn_left = 1; btn_right = 0; btn_jump = 0;
      game_tick = 1'b1;
      step();
      game_tick = 1'b0;
      chk("mid_enable_hi", coll_enable, 1);
      resetn = 1'b0;
      #1;
      chk("mid_enable_lo", coll_enable, 0);
      chk("mid_busy", busy, 0);
      chk("mid_x", x_location, 2);
      chk("mid_y", y_location, 1);
      chk("mid_overrun", tick_overrun, 0);
      step();
      resetn = 1'b1;
      repeat (3) step();
      chk("mid_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
